// File: rtl/calculator_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calculator_pkg;

  localparam int SLIDER_BITS = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HAVE_A = 2'd1,
    S_WAIT_B = 2'd2,
    S_EXEC   = 2'd3
  } calc_state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } calc_op_t;

endpackage

// File: rtl/calculator_edge_detect.sv
// Single-bit rising-edge detector: press is high for the first cycle a level is seen high.
module calculator_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign press = level & ~prev;

endmodule

// File: rtl/calculator_control.sv
// Operand/operator entry FSM with unsigned add/sub accumulator.
// Optional macro CALC_SATURATE_EN clamps the result on carry/borrow instead of wrapping.
module calculator_control
  import calculator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button_clr,
  input  logic             button_ent,
  input  logic             button_add,
  input  logic             button_sub,
  input  logic             slider_1,
  input  logic             slider_2,
  input  logic             slider_3,
  input  logic             slider_4,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       op_pending,
  output logic             busy,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  logic clr_press, ent_press, add_press, sub_press;
  logic [SLIDER_BITS-1:0] sliders;
  logic [WIDTH-1:0] slider_val;

  calc_state_t      state_q, state_d;
  calc_op_t         op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d, b_q, b_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum_ext, diff_ext;

  calculator_edge_detect u_ed_clr (.clk(clk), .reset(reset), .level(button_clr), .press(clr_press));
  calculator_edge_detect u_ed_ent (.clk(clk), .reset(reset), .level(button_ent), .press(ent_press));
  calculator_edge_detect u_ed_add (.clk(clk), .reset(reset), .level(button_add), .press(add_press));
  calculator_edge_detect u_ed_sub (.clk(clk), .reset(reset), .level(button_sub), .press(sub_press));

  assign sliders    = {slider_4, slider_3, slider_2, slider_1};
  assign slider_val = WIDTH'(sliders);

  // Extra top bit holds the add carry-out or the subtract borrow.
  assign sum_ext  = {1'b0, result_q} + {1'b0, b_q};
  assign diff_ext = {1'b0, result_q} - {1'b0, b_q};

  function automatic logic [WIDTH-1:0] exec_result(input calc_op_t op, input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH:0] s, input logic [WIDTH:0] d);
    logic [WIDTH-1:0] r;
    r = cur;
    if (op == OP_ADD) begin
`ifdef CALC_SATURATE_EN
      r = s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
      r = s[WIDTH-1:0];
`endif
    end else if (op == OP_SUB) begin
`ifdef CALC_SATURATE_EN
      r = d[WIDTH] ? {WIDTH{1'b0}} : d[WIDTH-1:0];
`else
      r = d[WIDTH-1:0];
`endif
    end
    return r;
  endfunction

  function automatic logic exec_carry(input calc_op_t op, input logic [WIDTH:0] s,
                                      input logic [WIDTH:0] d);
    logic c;
    c = 1'b0;
    if (op == OP_ADD)      c = s[WIDTH];
    else if (op == OP_SUB) c = d[WIDTH];
    return c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NONE;
      result_q <= '0;
      b_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      b_q      <= b_d;
      ovf_q    <= ovf_d;
    end
  end

  // Button priority clr > ent > add > sub falls out of the if/else ordering.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    b_d      = b_q;
    ovf_d    = ovf_q;
    if (clr_press) begin
      state_d  = S_IDLE;
      op_d     = OP_NONE;
      result_d = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ent_press) begin
            result_d = slider_val;
            ovf_d    = 1'b0;
            state_d  = S_HAVE_A;
          end
        end
        S_HAVE_A: begin
          if (ent_press) begin
            result_d = slider_val;
            ovf_d    = 1'b0;
          end else if (add_press) begin
            op_d    = OP_ADD;
            state_d = S_WAIT_B;
          end else if (sub_press) begin
            op_d    = OP_SUB;
            state_d = S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (ent_press) begin
            b_d     = slider_val;
            state_d = S_EXEC;
          end else if (add_press) begin
            op_d = OP_ADD;
          end else if (sub_press) begin
            op_d = OP_SUB;
          end
        end
        S_EXEC: begin
          result_d = exec_result(op_q, result_q, sum_ext, diff_ext);
          ovf_d    = ovf_q | exec_carry(op_q, sum_ext, diff_ext);
          op_d     = OP_NONE;
          state_d  = S_HAVE_A;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    result       = result_q;
    result_valid = (state_q == S_HAVE_A);
    busy         = (state_q == S_EXEC);
    op_pending   = op_q;
    overflow     = ovf_q;
    state_dbg    = state_q;
  end

endmodule

// File: tb/tb_calculator_control.sv
// Scoreboard bench for calculator_control (WIDTH=4) against a behavioural model.
module tb_calculator_control;

  localparam int W = 4;
  localparam int M = 1 << W;
`ifdef CALC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button_clr = 1'b0, button_ent = 1'b0, button_add = 1'b0, button_sub = 1'b0;
  logic slider_1 = 1'b0, slider_2 = 1'b0, slider_3 = 1'b0, slider_4 = 1'b0;
  logic [W-1:0] result;
  logic result_valid, busy, overflow;
  logic [1:0] op_pending, state_dbg;

  calculator_control #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .button_clr(button_clr), .button_ent(button_ent),
    .button_add(button_add), .button_sub(button_sub),
    .slider_1(slider_1), .slider_2(slider_2), .slider_3(slider_3), .slider_4(slider_4),
    .result(result), .result_valid(result_valid), .op_pending(op_pending),
    .busy(busy), .overflow(overflow), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res; int st; int op; int ovf; int bsy; int vld;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 have A, 2 waiting for B, 3 executing; op 0 none, 1 add, 2 sub.
  int m_st = 0, m_res = 0, m_b = 0, m_op = 0, m_ovf = 0;
  bit p_clr = 0, p_ent = 0, p_add = 0, p_sub = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("result", int'(result), e.res);
      check("state_dbg", int'(state_dbg), e.st);
      check("op_pending", int'(op_pending), e.op);
      check("overflow", int'(overflow), e.ovf);
      check("busy", int'(busy), e.bsy);
      check("result_valid", int'(result_valid), e.vld);
    end
  end

  task automatic model_step(input bit r, input bit c, input bit e, input bit a, input bit s,
                            input int sl);
    bit pc, pe, pa, ps;
    int t;
    if (r) begin
      m_st = 0; m_res = 0; m_b = 0; m_op = 0; m_ovf = 0;
      p_clr = 0; p_ent = 0; p_add = 0; p_sub = 0;
      return;
    end
    pc = c && !p_clr; pe = e && !p_ent; pa = a && !p_add; ps = s && !p_sub;
    p_clr = c; p_ent = e; p_add = a; p_sub = s;
    if (pc) begin
      m_res = 0; m_op = 0; m_ovf = 0; m_st = 0;
    end else if (m_st == 3) begin
      if (m_op == 1) begin
        t = m_res + m_b;
        if (t >= M) begin m_ovf = 1; t = SAT ? M - 1 : t - M; end
      end else begin
        t = m_res - m_b;
        if (t < 0) begin m_ovf = 1; t = SAT ? 0 : t + M; end
      end
      m_res = t; m_op = 0; m_st = 1;
    end else if (pe) begin
      if (m_st == 2) begin m_b = sl; m_st = 3; end
      else begin m_res = sl; m_ovf = 0; m_st = 1; end
    end else if ((pa || ps) && m_st != 0) begin
      m_op = pa ? 1 : 2;
      m_st = 2;
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit e, input bit a, input bit s,
                       input int sl);
    exp_t x;
    @(negedge clk); #1;
    reset = r; button_clr = c; button_ent = e; button_add = a; button_sub = s;
    slider_1 = sl[0]; slider_2 = sl[1]; slider_3 = sl[2]; slider_4 = sl[3];
    model_step(r, c, e, a, s, sl);
    @(posedge clk); #1;
    x.res = m_res; x.st = m_st; x.op = m_op; x.ovf = m_ovf;
    x.bsy = (m_st == 3) ? 1 : 0;
    x.vld = (m_st == 1) ? 1 : 0;
    sb.push_back(x);
  endtask

  task automatic press(input bit c, input bit e, input bit a, input bit s, input int sl);
    drive(1'b0, c, e, a, s, sl);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sl);
  endtask

  task automatic expect_now(input string name, input int res, input int st, input int ovf);
    check({name, "_result"}, int'(result), res);
    check({name, "_state"}, int'(state_dbg), st);
    check({name, "_ovf"}, int'(overflow), ovf);
  endtask

  initial begin
    // reset held two cycles, then released
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    expect_now("reset", 0, 0, 0);

    // basic add with a held ent level that must load only once
    drive(0, 0, 1, 0, 0, 5);
    drive(0, 0, 1, 0, 0, 7);
    drive(0, 0, 1, 0, 0, 7);
    drive(0, 0, 0, 0, 0, 7);
    expect_now("held_ent", 5, 1, 0);
    press(0, 0, 1, 0, 0);
    press(0, 1, 0, 0, 3);
    expect_now("add5_3", 8, 1, 0);

    // carry and borrow
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 12);
    press(0, 0, 1, 0, 0);
    press(0, 1, 0, 0, 7);
    expect_now("carry", SAT ? 15 : 3, 1, 1);
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 2);
    press(0, 0, 0, 1, 0);
    press(0, 1, 0, 0, 9);
    expect_now("borrow", SAT ? 0 : 9, 1, 1);

    // priority and ignored presses
    press(0, 1, 0, 0, 4);
    press(1, 1, 0, 0, 6);
    expect_now("clr_ent", 0, 0, 0);
    press(0, 0, 1, 0, 9);
    expect_now("add_idle", 0, 0, 0);
    press(0, 1, 0, 0, 3);
    press(0, 0, 1, 0, 0);
    press(0, 0, 0, 1, 0);
    check("op_replace", int'(op_pending), 2);
    press(1, 0, 0, 0, 0);

    // chaining, then reload clears overflow
    press(0, 1, 0, 0, 10);
    press(0, 0, 1, 0, 0);
    press(0, 1, 0, 0, 4);
    expect_now("chain_add", 14, 1, 0);
    press(0, 0, 0, 1, 0);
    press(0, 1, 0, 0, 6);
    expect_now("chain_sub", 8, 1, 0);
    press(0, 1, 0, 0, 1);
    expect_now("reload", 1, 1, 0);

    // clr while executing
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 5);
    press(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 3);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    expect_now("clr_exec", 0, 0, 0);

    // asynchronous reset while executing
    press(0, 1, 0, 0, 5);
    press(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 3);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    expect_now("rst_exec", 0, 0, 0);
    check("rst_exec_busy", int'(busy), 0);
    model_step(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 15)));
    end

    @(negedge clk); #1;
    check("scoreboard_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calculator_control.md
Name: calculator_control

Overview:
Sequencing controller for the calculator datapath. Sits directly downstream of calculator_input and consumes its debounced button levels (clr/ent/add/sub) and four debounced slider bits.
- Edge-detects the buttons.
- Runs an operand/operator entry FSM.
- Performs unsigned add/sub into an accumulator.
- Presents the accumulator, status flags and FSM state to the display logic.

Parameters:
WIDTH, 8, accumulator/result width in bits (must be >= 4)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
button_clr  input  1  debounced clear level
button_ent  input  1  debounced enter level
button_add  input  1  debounced add level
button_sub  input  1  debounced subtract level
slider_1  input  1  operand bit 0 (LSB)
slider_2  input  1  operand bit 1
slider_3  input  1  operand bit 2
slider_4  input  1  operand bit 3 (MSB)
result  output  WIDTH  accumulator value
result_valid  output  1  high in S_HAVE_A
op_pending  output  2  pending operator: 0 none, 1 add, 2 sub
busy  output  1  high in S_EXEC
overflow  output  1  sticky carry/borrow flag
state_dbg  output  2  current FSM state encoding

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is high:
  - state is S_IDLE;
  - result, operand B, op_pending, overflow, busy and result_valid are 0;
  - all edge-detect previous-level registers are cleared.
  Reset mid-operation (any state, including S_EXEC) aborts immediately with no partial accumulator update.
- Edge detect: per button, press = level & ~prev, where prev is the level registered on the previous cycle. A level held high produces exactly one press.
- Operand: the slider value {slider_4,slider_3,slider_2,slider_1} is zero-extended to WIDTH and sampled on the cycle the press is seen.
- Same-cycle priority: clr > ent > add > sub. Lower-priority presses in the same cycle are discarded.
- States (2-bit encoding): S_IDLE=0, S_HAVE_A=1, S_WAIT_B=2, S_EXEC=3.
  - clr press, any state except under reset: result := 0, op := none, overflow := 0, next state S_IDLE. In S_EXEC, clr wins over the pending update.
  - S_IDLE: ent -> result := slider, overflow := 0, next S_HAVE_A. add/sub are ignored.
  - S_HAVE_A: ent -> reload result := slider, overflow := 0, stay. add -> op := add, next S_WAIT_B. sub -> op := sub, next S_WAIT_B.
  - S_WAIT_B: ent -> B := slider, next S_EXEC. add/sub replace the pending op and stay in S_WAIT_B.
  - S_EXEC: lasts exactly one cycle and ignores button presses except clr (presses are still consumed by the edge detectors). It computes result := result op B, sets overflow if any operation since the last clr or reload carried or borrowed, clears op to none, then goes to S_HAVE_A. Chaining (add again) is therefore allowed.
- Arithmetic: unsigned, WIDTH bits.
  - add overflow = carry-out of bit WIDTH-1.
  - sub overflow = borrow (B > result).
  - Default behaviour wraps modulo 2^WIDTH.
- Latency:
  - A press seen before clock edge k updates state at edge k.
  - From an ent press in S_WAIT_B, the new result is valid after edge k+1: S_EXEC occupies k..k+1, and result_valid is high from k+1.
- Outputs are registered or decoded from registered state only; no combinational path from button inputs to outputs.

Optional Feature:
CALC_SATURATE_EN
- Defined: on overflow in S_EXEC, result clamps to all-ones (add) or 0 (sub); overflow flag is set as normal.
- Undefined: result wraps modulo 2^WIDTH; overflow flag is identical.

Decomposition:
- calculator_pkg holds:
  - calc_state_t enum: S_IDLE, S_HAVE_A, S_WAIT_B, S_EXEC;
  - calc_op_t enum: OP_NONE=0, OP_ADD=1, OP_SUB=2;
  - SLIDER_BITS=4 constant.
- One sub-module, calculator_edge_detect: 1-bit rising-edge detector with async reset, instantiated four times.

Test Plan:
1. Reset: hold reset 2 cycles then release -> result=0, state_dbg=0, result_valid=0, overflow=0; drop reset during S_EXEC -> immediately S_IDLE, result=0.
2. Basic add: sliders=5, ent; add; sliders=3, ent -> busy for 1 cycle, then result=8, result_valid=1, op_pending=0, overflow=0. A held ent level yields only one load.
3. Wrap/saturate, WIDTH=4: load 12, add, 7 -> overflow=1 with result=3 (default) or result=15 (CALC_SATURATE_EN). Load 2, sub, 9 -> overflow=1 with result=9 (default) or 0 (saturate).
4. Priority and ignore:
   - clr and ent pressed same cycle in S_HAVE_A -> S_IDLE, result=0.
   - add in S_IDLE -> no change.
   - add then sub in S_WAIT_B -> op_pending=2.
5. Chaining: load 10, add 4 -> 14; sub 6 -> 8; ent with sliders=1 -> result=1, overflow=0.
6. clr during S_EXEC (load 5, add, 3, clr on cycle after ent) -> result=0, S_IDLE, no 8 ever appears on result.
